// File: rtl/epc_stack.sv
// Exception-return PC stack: nested {pc, cause} entries for exception entry/eret,
// with a combinational top-of-stack read and sticky overflow/underflow debug flags.
module epc_stack #(
    parameter int  WIDTH   = 32,
    parameter int  DEPTH   = 4,
    parameter int  CAUSE_W = 5,
    localparam int CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               push,
    input  logic [WIDTH-1:0]   push_pc,
    input  logic [CAUSE_W-1:0] push_cause,
    input  logic               pop,
    input  logic               wr_top,
    input  logic [WIDTH-1:0]   wr_data,
    input  logic               clr_err,
    output logic [WIDTH-1:0]   top_pc,
    output logic [CAUSE_W-1:0] top_cause,
    output logic [CNT_W-1:0]   level,
    output logic               empty,
    output logic               full,
    output logic               in_handler,
    output logic               overflow,
    output logic               underflow
);

    localparam int IDX_W = $clog2(DEPTH);

    logic [WIDTH-1:0]   pc_mem    [DEPTH];
    logic [CAUSE_W-1:0] cause_mem [DEPTH];

    logic [CNT_W-1:0]   level_nxt;
    logic [IDX_W-1:0]   top_idx;
    logic [IDX_W-1:0]   w_idx;
    logic [WIDTH-1:0]   w_pc;
    logic [CAUSE_W-1:0] w_cause;
    logic               pc_we;
    logic               cause_we;
    logic               ovf_set;
    logic               unf_set;

    assign empty      = (level == '0);
    assign full       = (level == CNT_W'(DEPTH));
    assign in_handler = ~empty;
    assign top_idx    = IDX_W'(level - CNT_W'(1));

    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        level_nxt = level;
        w_idx     = top_idx;
        w_pc      = push_pc;
        w_cause   = push_cause;
        pc_we     = 1'b0;
        cause_we  = 1'b0;
        ovf_set   = 1'b0;
        unf_set   = 1'b0;
        case ({push, pop})
            2'b10: begin
                if (!full) begin
                    pc_we     = 1'b1;
                    cause_we  = 1'b1;
                    w_idx     = IDX_W'(level);
                    level_nxt = level + CNT_W'(1);
                end else begin
                    ovf_set = 1'b1;
                end
            end
            2'b01: begin
                if (!empty) level_nxt = level - CNT_W'(1);
                else        unf_set   = 1'b1;
            end
            2'b11: begin
                // eret followed by a new exception: replace the top in place
                pc_we    = 1'b1;
                cause_we = 1'b1;
                if (empty) begin
                    w_idx     = '0;
                    level_nxt = CNT_W'(1);
                    unf_set   = 1'b1;
                end
            end
            default: begin
                if (wr_top && !empty) begin
                    pc_we = 1'b1;
                    w_pc  = wr_data;
                end
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            level     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            level     <= level_nxt;
            overflow  <= ovf_set | (overflow  & ~clr_err);
            underflow <= unf_set | (underflow & ~clr_err);
        end
    end

    // NOTE: the entry array is not reset; stale entries are never visible because outputs are masked when empty.
    always_ff @(posedge clk) begin
        if (pc_we)    pc_mem[w_idx]    <= w_pc;
        if (cause_we) cause_mem[w_idx] <= w_cause;
    end

    assign top_pc    = empty ? '0 : pc_mem[top_idx];
    assign top_cause = empty ? '0 : cause_mem[top_idx];

endmodule

// File: tb/tb_epc_stack.sv
// Self-checking bench for epc_stack: directed vector table, reset-in-nest sequence,
// and randomized traffic against a queue-based reference model.
`timescale 1ns/1ps
module tb_epc_stack;

    localparam int WIDTH   = 32;
    localparam int DEPTH   = 4;
    localparam int CAUSE_W = 5;
    localparam int CNT_W   = $clog2(DEPTH + 1);

    logic               clk = 1'b0;
    logic               reset;
    logic               push, pop, wr_top, clr_err;
    logic [WIDTH-1:0]   push_pc, wr_data;
    logic [CAUSE_W-1:0] push_cause;
    logic [WIDTH-1:0]   top_pc;
    logic [CAUSE_W-1:0] top_cause;
    logic [CNT_W-1:0]   level;
    logic               empty, full, in_handler, overflow, underflow;

    int total = 0;
    int bad   = 0;

    epc_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CAUSE_W(CAUSE_W)) dut (
        .clk(clk), .reset(reset),
        .push(push), .push_pc(push_pc), .push_cause(push_cause),
        .pop(pop), .wr_top(wr_top), .wr_data(wr_data), .clr_err(clr_err),
        .top_pc(top_pc), .top_cause(top_cause), .level(level),
        .empty(empty), .full(full), .in_handler(in_handler),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        push, pop, wr, clr;
        logic [31:0] pc;
        logic [4:0]  cause;
        logic [31:0] wd;
        int          lvl;
        logic [31:0] epc;
        logic [4:0]  ecause;
        logic        eovf, eunf;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [4:0]  cause;
    } entry_t;

    vec_t   vecs[$];
    entry_t model_q[$];
    logic   m_ovf, m_unf;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input int lvl, input logic [31:0] epc,
                             input logic [4:0] ecause, input logic eovf, input logic eunf);
        check({tag, " level"},      64'(level),      64'(lvl));
        check({tag, " top_pc"},     64'(top_pc),     64'(epc));
        check({tag, " top_cause"},  64'(top_cause),  64'(ecause));
        check({tag, " empty"},      64'(empty),      64'(lvl == 0));
        check({tag, " full"},       64'(full),       64'(lvl == DEPTH));
        check({tag, " in_handler"}, 64'(in_handler), 64'(lvl != 0));
        check({tag, " overflow"},   64'(overflow),   64'(eovf));
        check({tag, " underflow"},  64'(underflow),  64'(eunf));
    endtask

    // Drive one cycle of inputs, let the edge sample them, then idle the inputs.
    task automatic step(input logic p, input logic po, input logic w, input logic c,
                        input logic [31:0] pc, input logic [4:0] cause, input logic [31:0] wd);
        push = p; pop = po; wr_top = w; clr_err = c;
        push_pc = pc; push_cause = cause; wr_data = wd;
        @(posedge clk);
        #1;
        push = 1'b0; pop = 1'b0; wr_top = 1'b0; clr_err = 1'b0;
    endtask

    task automatic add(input logic p, input logic po, input logic w, input logic c,
                       input logic [31:0] pc, input logic [4:0] cause, input logic [31:0] wd,
                       input int lvl, input logic [31:0] epc, input logic [4:0] ecause,
                       input logic eovf, input logic eunf);
        vec_t v;
        v = '{p, po, w, c, pc, cause, wd, lvl, epc, ecause, eovf, eunf};
        vecs.push_back(v);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        #3;
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Reference model: stack rules applied to a queue, top at the back.
    task automatic model_step(input logic p, input logic po, input logic w, input logic c,
                              input logic [31:0] pc, input logic [4:0] cause, input logic [31:0] wd);
        logic os, us;
        entry_t e;
        os = 1'b0; us = 1'b0;
        e.pc = pc; e.cause = cause;
        if (p && !po) begin
            if (model_q.size() < DEPTH) model_q.push_back(e);
            else os = 1'b1;
        end else if (po && !p) begin
            if (model_q.size() > 0) void'(model_q.pop_back());
            else us = 1'b1;
        end else if (p && po) begin
            if (model_q.size() > 0) model_q[model_q.size()-1] = e;
            else begin
                model_q.push_back(e);
                us = 1'b1;
            end
        end else if (w && model_q.size() > 0) begin
            model_q[model_q.size()-1].pc = wd;
        end
        m_ovf = os | (m_ovf & ~c);
        m_unf = us | (m_unf & ~c);
    endtask

    initial begin
        reset = 1'b1;
        push = 1'b0; pop = 1'b0; wr_top = 1'b0; clr_err = 1'b0;
        push_pc = '0; push_cause = '0; wr_data = '0;

        do_reset();
        check_all("reset", 0, 32'h0, 5'd0, 1'b0, 1'b0);

        //   push pop wr clr  pc            cause  wdata          lvl  top_pc        cause ovf unf
        add(1, 0, 0, 0, 32'h0040_0010, 5'd0,  32'h0,          1, 32'h0040_0010, 5'd0,  0, 0);
        add(1, 0, 0, 0, 32'h0040_0020, 5'd8,  32'h0,          2, 32'h0040_0020, 5'd8,  0, 0);
        add(1, 0, 0, 0, 32'h0040_0030, 5'd12, 32'h0,          3, 32'h0040_0030, 5'd12, 0, 0);
        add(0, 1, 0, 0, 32'h0,         5'd0,  32'h0,          2, 32'h0040_0020, 5'd8,  0, 0);
        add(0, 1, 0, 0, 32'h0,         5'd0,  32'h0,          1, 32'h0040_0010, 5'd0,  0, 0);
        add(0, 1, 0, 0, 32'h0,         5'd0,  32'h0,          0, 32'h0,         5'd0,  0, 0);
        add(1, 0, 0, 0, 32'h0040_1000, 5'd1,  32'h0,          1, 32'h0040_1000, 5'd1,  0, 0);
        add(1, 0, 0, 0, 32'h0040_2000, 5'd2,  32'h0,          2, 32'h0040_2000, 5'd2,  0, 0);
        add(1, 0, 0, 0, 32'h0040_3000, 5'd3,  32'h0,          3, 32'h0040_3000, 5'd3,  0, 0);
        add(1, 0, 0, 0, 32'h0040_4000, 5'd4,  32'h0,          4, 32'h0040_4000, 5'd4,  0, 0);
        add(1, 0, 0, 0, 32'h0040_5000, 5'd5,  32'h0,          4, 32'h0040_4000, 5'd4,  1, 0);
        add(0, 0, 0, 1, 32'h0,         5'd0,  32'h0,          4, 32'h0040_4000, 5'd4,  0, 0);
        add(1, 0, 0, 1, 32'h0040_5000, 5'd5,  32'h0,          4, 32'h0040_4000, 5'd4,  1, 0);
        add(0, 0, 0, 1, 32'h0,         5'd0,  32'h0,          4, 32'h0040_4000, 5'd4,  0, 0);
        add(0, 1, 0, 0, 32'h0,         5'd0,  32'h0,          3, 32'h0040_3000, 5'd3,  0, 0);
        add(0, 1, 0, 0, 32'h0,         5'd0,  32'h0,          2, 32'h0040_2000, 5'd2,  0, 0);
        add(0, 1, 0, 0, 32'h0,         5'd0,  32'h0,          1, 32'h0040_1000, 5'd1,  0, 0);
        add(0, 1, 0, 0, 32'h0,         5'd0,  32'h0,          0, 32'h0,         5'd0,  0, 0);
        add(0, 1, 0, 0, 32'h0,         5'd0,  32'h0,          0, 32'h0,         5'd0,  0, 1);
        add(1, 1, 0, 0, 32'h8000_0180, 5'd0,  32'h0,          1, 32'h8000_0180, 5'd0,  0, 1);
        add(0, 0, 0, 1, 32'h0,         5'd0,  32'h0,          1, 32'h8000_0180, 5'd0,  0, 0);
        add(1, 0, 0, 0, 32'h0040_0050, 5'd9,  32'h0,          2, 32'h0040_0050, 5'd9,  0, 0);
        add(1, 1, 0, 0, 32'h0040_0100, 5'd4,  32'h0,          2, 32'h0040_0100, 5'd4,  0, 0);
        add(0, 1, 0, 0, 32'h0,         5'd0,  32'h0,          1, 32'h8000_0180, 5'd0,  0, 0);
        add(0, 0, 1, 0, 32'h0,         5'd0,  32'h0040_0200,  1, 32'h0040_0200, 5'd0,  0, 0);
        add(1, 0, 1, 0, 32'h0040_0300, 5'd6,  32'hDEAD_BEEF,  2, 32'h0040_0300, 5'd6,  0, 0);
        add(0, 1, 0, 0, 32'h0,         5'd0,  32'h0,          1, 32'h0040_0200, 5'd0,  0, 0);
        add(0, 1, 1, 0, 32'h0,         5'd0,  32'h1111_1111,  0, 32'h0,         5'd0,  0, 0);
        add(0, 0, 1, 0, 32'h0,         5'd0,  32'h2222_2222,  0, 32'h0,         5'd0,  0, 0);
        add(0, 1, 0, 1, 32'h0,         5'd0,  32'h0,          0, 32'h0,         5'd0,  0, 1);
        add(0, 0, 0, 1, 32'h0,         5'd0,  32'h0,          0, 32'h0,         5'd0,  0, 0);
        add(1, 0, 0, 0, 32'h0040_0400, 5'd7,  32'h0,          1, 32'h0040_0400, 5'd7,  0, 0);
        add(0, 0, 1, 0, 32'h0,         5'd0,  32'h0040_0444,  1, 32'h0040_0444, 5'd7,  0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].push, vecs[i].pop, vecs[i].wr, vecs[i].clr,
                 vecs[i].pc, vecs[i].cause, vecs[i].wd);
            check_all($sformatf("vec%0d", i), vecs[i].lvl, vecs[i].epc,
                      vecs[i].ecause, vecs[i].eovf, vecs[i].eunf);
        end

        // Reset asserted between edges mid-nest must clear outputs immediately.
        do_reset();
        for (int i = 0; i < DEPTH; i++) step(1, 0, 0, 0, 32'h0050_0000 + 32'(i), 5'(i + 1), 32'h0);
        step(1, 0, 0, 0, 32'h0050_00FF, 5'd9, 32'h0);
        step(0, 1, 0, 0, 32'h0, 5'd0, 32'h0);
        check_all("pre_rst", 3, 32'h0050_0002, 5'd3, 1'b1, 1'b0);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check_all("async_rst", 0, 32'h0, 5'd0, 1'b0, 1'b0);
        @(posedge clk);
        #2;
        reset = 1'b1;
        @(posedge clk);
        #1;
        step(1, 0, 0, 0, 32'h0000_1234, 5'd2, 32'h0);
        check_all("post_rst", 1, 32'h0000_1234, 5'd2, 1'b0, 1'b0);

        // Randomized traffic against the queue model.
        do_reset();
        model_q.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        for (int n = 0; n < 400; n++) begin
            logic p, po, w, c;
            logic [31:0] pc, wd;
            logic [4:0]  cause;
            p     = ($urandom_range(0, 99) < 45);
            po    = ($urandom_range(0, 99) < 40);
            w     = ($urandom_range(0, 99) < 20);
            c     = ($urandom_range(0, 99) < 8);
            pc    = $urandom;
            wd    = $urandom;
            cause = 5'($urandom);
            step(p, po, w, c, pc, cause, wd);
            model_step(p, po, w, c, pc, cause, wd);
            if (model_q.size() > 0)
                check_all($sformatf("rnd%0d", n), model_q.size(),
                          model_q[model_q.size()-1].pc, model_q[model_q.size()-1].cause,
                          m_ovf, m_unf);
            else
                check_all($sformatf("rnd%0d", n), 0, 32'h0, 5'd0, m_ovf, m_unf);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/epc_stack.md
# epc_stack

Parametrised exception-return-PC stack for the pipelined MIPS CPU, supporting nested exceptions and interrupts. On each exception entry it captures the PC and cause of the interrupted instruction. On each `eret` it restores the previous level, and it exposes the current top entry to the PC-select logic and to CP0 reads. It sits beside the exception/interrupt controller in the ID/EX stage and flags overflow and underflow for debug.

## Interface
Parameters:
- `WIDTH`, 32, PC width in bits.
- `DEPTH`, 4, maximum nesting levels; legal range ≥ 2.
- `CAUSE_W`, 5, cause-code width.
- `CNT_W`, `$clog2(DEPTH+1)`, occupancy-counter width (derived, not overridden).

Ports:
- `clk` in 1: single clock, rising-edge.
- `reset` in 1: asynchronous, active-low; all state clears while low.
- `push` in 1: exception entry; capture `push_pc` and `push_cause`.
- `push_pc` in WIDTH: PC to save (the faulting or interrupted instruction).
- `push_cause` in CAUSE_W: cause code of the entry.
- `pop` in 1: `eret`; discard the top entry.
- `wr_top` in 1: software write (`mtc0` EPC) of the top PC.
- `wr_data` in WIDTH: data for `wr_top`.
- `clr_err` in 1: clear the sticky error flags.
- `top_pc` out WIDTH: PC of the top entry; 0 when empty.
- `top_cause` out CAUSE_W: cause of the top entry; 0 when empty.
- `level` out CNT_W: current occupancy, 0..DEPTH.
- `empty` out 1: `level == 0`.
- `full` out 1: `level == DEPTH`.
- `in_handler` out 1: same as `~empty`; feeds the kernel-mode indication.
- `overflow` out 1: sticky; set when a push was dropped.
- `underflow` out 1: sticky; set when a pop hit an empty stack.

## Operation
- Storage is DEPTH entries of {pc, cause} plus a `level` counter; there is no separate pointer.
- Entries are written at index `level` and the top is read at index `level-1`.
- **push only**
  - Not full: write the entry, `level+1`.
  - Full: the push is dropped, contents unchanged, `overflow` is set.
- **pop only**
  - Not empty: `level-1`. The old entry is not cleared but is no longer visible.
  - Empty: no change, `underflow` is set.
- **push and pop in the same cycle**
  - Not empty: the top entry is replaced by the new {pc, cause} and `level` is unchanged. This covers a return immediately followed by a new exception.
  - Empty: the push proceeds, `level` becomes 1, `underflow` is set.
- **wr_top**
  - Only when neither push nor pop is active and the stack is not empty: overwrite the top pc; cause is unchanged.
  - Ignored otherwise; push/pop have priority.
  - `wr_top` when empty is ignored and sets no flag.
- **Error flags**
  - `clr_err` clears both flags.
  - A set event in the same cycle as `clr_err` wins: the flag stays 1.
- **Outputs**
  - `top_pc` and `top_cause` are a combinational read of the registered state.
  - They are forced to 0 when `level == 0`.
  - `empty`, `full` and `in_handler` are decoded from `level`.
- **Reset**
  - Asserting `reset` (low) at any time, including mid-nest, immediately forces `level=0`, `overflow=0`, `underflow=0`.
  - Array contents are don't-care after reset but are never visible, because outputs are masked when empty.

## Timing
- All state updates happen on the rising edge of `clk` and are visible right after that edge.
- Push-to-top latency is 1 cycle. A push sampled at edge k shows `top_pc=push_pc` after edge k.
- Pop latency is 1 cycle. The previous level is visible after the sampling edge.
- Back-to-back push/pop every cycle is supported with no bubble cycles.
- Reset release is asynchronous assert; the first update is on the first rising edge after `reset` goes high.
- `level` counts 0..DEPTH and never wraps; saturation is enforced by the overflow/underflow rules above.

## Test plan
- Reset, then 3 pushes (PC 0x00400010/0x00400020/0x00400030, causes 0/8/12) → `level=3`, `top_pc=0x00400030`, `top_cause=12`. Then 3 pops → tops 0x00400020, 0x00400010, then 0 with `empty=1`.
- With DEPTH=4, 5 pushes → `full=1` after the 4th. The 5th is dropped: `overflow=1`, `top_pc` = the 4th PC. Then `clr_err` → `overflow=0`.
- Pop when empty → `underflow=1`, `level=0`. Then simultaneous push (0x80000180) and pop on the empty stack → `level=1`, `top_pc=0x80000180`, `underflow` still 1.
- `level=2`, simultaneous push (0x00400100, cause 4) and pop → `level=2`, top replaced with {0x00400100, 4}, lower entry intact after one further pop.
- `level=1`, `wr_top` with 0x00400200 → `top_pc=0x00400200`, cause unchanged. `wr_top` together with push → the push wins and `wr_data` is ignored.
- `level=3`; drive `reset` low between clock edges → all outputs 0 and `empty=1` immediately, without waiting for an edge. Release reset, then push 0x1234 → `level=1`, `top_pc=0x1234`.
